// File: rtl/cacheline_mem_arbiter_if.sv
// Cache-side and pmem-side line bus shared by the I-cache, D-cache and pmem.
// The slave modport is the arbiter's view; master is the surrounding system.
interface cacheline_mem_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// Shares the pmem line port between I-cache and D-cache.
// D-cache wins ties, but a bounded streak guarantees fetch progress.
module cacheline_mem_arbiter #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int D_STREAK_MAX = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    cacheline_mem_arbiter_if.slave bus
);
    localparam int SW = $clog2(D_STREAK_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(D_STREAK_MAX);

    typedef enum logic [2:0] {
        IDLE,
        I_BUSY,
        D_BUSY,
        I_RESP,
        D_RESP
    } state_t;

    state_t            state;
    logic [SW-1:0]     streak;
    logic              rd_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_q;
    logic              i_resp_q;
    logic              d_resp_q;
    logic              d_req;
    logic              i_forced;

    assign d_req    = bus.d_read | bus.d_write;
    assign i_forced = bus.i_read && (streak == SMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            streak   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            line_q   <= '0;
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_req && !i_forced) begin
                        state   <= D_BUSY;
                        addr_q  <= bus.d_addr;
                        wdata_q <= bus.d_wdata;
                        // write wins when a cache raises both
                        wr_q    <= bus.d_write;
                        rd_q    <= !bus.d_write;
                        if (!bus.i_read)
                            streak <= '0;
                        else if (streak != SMAX)
                            streak <= streak + SW'(1);
                    end else if (bus.i_read) begin
                        state  <= I_BUSY;
                        addr_q <= bus.i_addr;
                        rd_q   <= 1'b1;
                        wr_q   <= 1'b0;
                        streak <= '0;
                    end
                end
                I_BUSY, D_BUSY: begin
                    if (bus.pmem_resp) begin
                        line_q   <= bus.pmem_rdata;
                        rd_q     <= 1'b0;
                        wr_q     <= 1'b0;
                        i_resp_q <= (state == I_BUSY);
                        d_resp_q <= (state == D_BUSY);
                        state    <= (state == I_BUSY) ? I_RESP : D_RESP;
                    end
                end
                I_RESP, D_RESP: state <= IDLE;
                default:        state <= IDLE;
            endcase
        end
    end

    assign bus.pmem_read  = rd_q;
    assign bus.pmem_write = wr_q;
    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.i_rdata    = line_q;
    assign bus.d_rdata    = line_q;
    assign bus.i_resp     = i_resp_q;
    assign bus.d_resp     = d_resp_q;
endmodule
